// File: rtl/fifo_read_streamer.sv
// Read-side consumer for a 1-cycle-latency FIFO: issues reads, buffers up to three
// words and presents them as a valid/ready stream framed into PKT_LEN-word packets.
module fifo_read_streamer #(
    parameter int WIDTH   = 32,
    parameter int PKT_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_r_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] pkt_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_buf [3];
    logic [1:0]       r_head;
    logic [1:0]       r_tail;
    logic [1:0]       r_occ;
    logic             r_inflight;
    logic [15:0]      r_beat;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_pkt_cnt;

    logic       w_push;
    logic       w_pop;
    logic       w_last;
    logic [2:0] w_pending;
    logic [1:0] w_occ_next;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reads are gated on words already owned (buffered or in flight), never on m_ready.
    assign w_pending  = {1'b0, r_occ} + {2'b00, r_inflight};
    assign fifo_r_en  = enable & ~fifo_empty & (r_state != DRAIN) & (w_pending < 3'd3);

    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_buf[r_head];
    assign w_last     = (r_beat == LAST_BEAT);
    assign m_last     = m_valid & w_last;
    assign busy       = (r_state != IDLE);
    assign word_count = r_word_cnt;
    assign pkt_count  = r_pkt_cnt;

    assign w_push = r_inflight;
    assign w_pop  = m_valid & m_ready;

    always_comb begin
        w_occ_next = r_occ;
        if (w_push && !w_pop) begin
            w_occ_next = r_occ + 2'd1;
        end else if (!w_push && w_pop) begin
            w_occ_next = r_occ - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_beat     <= 16'd0;
            r_word_cnt <= '0;
            r_pkt_cnt  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= fifo_r_en;
            r_occ      <= w_occ_next;

            if (w_push) begin
                r_buf[r_tail] <= fifo_data_out;
                r_tail        <= ptr_inc(r_tail);
            end

            if (w_pop) begin
                r_head     <= ptr_inc(r_head);
                r_word_cnt <= r_word_cnt + CNT_W'(1);
                if (w_last) begin
                    r_beat    <= 16'd0;
                    r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
                end else begin
                    r_beat <= r_beat + 16'd1;
                end
            end

            // DRAIN exits as soon as the final buffered word leaves, so busy drops right after it.
            case (r_state)
                IDLE: begin
                    if (enable && !fifo_empty) r_state <= ACTIVE;
                end
                ACTIVE: begin
                    if (!enable) r_state <= (r_occ != 2'd0 || r_inflight) ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (enable) begin
                        r_state <= ACTIVE;
                    end else if (w_occ_next == 2'd0) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_read_streamer.sv
// Scoreboard bench for fifo_read_streamer: a queue-based FIFO model feeds the DUT,
// stimulus pushes expected words, a negedge monitor pops and compares on each handshake.
module tb_fifo_read_streamer;
    localparam int W   = 32;
    localparam int PKT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          m_ready = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [W-1:0]  fifo_data_out = '0;

    logic          fifo_r_en, m_valid, m_last, busy;
    logic [W-1:0]  m_data;
    logic [15:0]   word_count, pkt_count;

    logic          r_en2, mv2, ml2, bz2;
    logic [W-1:0]  md2;
    logic [3:0]    wc2, pc2;

    logic          r_en3, mv3, ml3, bz3;
    logic [W-1:0]  md3;
    logic [15:0]   wc3, pc3;

    fifo_read_streamer #(.WIDTH(W), .PKT_LEN(PKT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_r_en(fifo_r_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy),
        .word_count(word_count), .pkt_count(pkt_count));

    fifo_read_streamer #(.WIDTH(W), .PKT_LEN(PKT), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_r_en(r_en2), .m_valid(mv2),
        .m_ready(m_ready), .m_data(md2), .m_last(ml2), .busy(bz2),
        .word_count(wc2), .pkt_count(pc2));

    fifo_read_streamer #(.WIDTH(W), .PKT_LEN(1), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_r_en(r_en3), .m_valid(mv3),
        .m_ready(m_ready), .m_data(md3), .m_last(ml3), .busy(bz3),
        .word_count(wc3), .pkt_count(pc3));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int issued = 0;
    int xfer = 0;
    int exp_beat = 0;

    logic [W-1:0] wr_q [$];
    logic [W-1:0] mem [$];
    logic [W-1:0] exp_d [$];
    logic         exp_l [$];

    logic         hold_v = 1'b0;
    logic [W-1:0] hold_d = '0;
    logic         hold_l = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // FIFO model: registered empty flag, read data one cycle after an accepted read.
    always @(posedge clk) begin
        if (rst) begin
            mem.delete();
            wr_q.delete();
            fifo_empty <= 1'b1;
        end else begin
            if (fifo_r_en && mem.size() > 0) fifo_data_out <= mem.pop_front();
            while (wr_q.size() > 0) mem.push_back(wr_q.pop_front());
            fifo_empty <= (mem.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            issued = 0;
            xfer   = 0;
            hold_v = 1'b0;
        end else begin
            if (fifo_empty) chk("ren_while_empty", {63'd0, fifo_r_en}, 64'd0);
            if (hold_v) begin
                chk("stall_valid", {63'd0, m_valid}, 64'd1);
                chk("stall_data", {32'd0, m_data}, {32'd0, hold_d});
                chk("stall_last", {63'd0, m_last}, {63'd0, hold_l});
            end
            if (fifo_r_en) issued++;
            if (m_valid && m_ready) begin
                xfer++;
                if (exp_d.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_unexpected: got word 0x%0h, expected none at %0t", m_data, $time);
                end else begin
                    chk("sb_data", {32'd0, m_data}, {32'd0, exp_d.pop_front()});
                    chk("sb_last", {63'd0, m_last}, {63'd0, exp_l.pop_front()});
                end
            end
            chk("outstanding_le3", {63'd0, (issued - xfer) <= 3}, 64'd1);
            if (mv3) chk("len1_last", {63'd0, ml3}, 64'd1);
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_q.push_back(base + W'(i));
            exp_d.push_back(base + W'(i));
            exp_l.push_back(exp_beat == PKT - 1);
            exp_beat = (exp_beat == PKT - 1) ? 0 : exp_beat + 1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_d.delete();
        exp_l.delete();
        exp_beat = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int n = 0;
        while (!m_valid && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_wait_valid"}, {63'd0, m_valid}, 64'd1);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while ((exp_d.size() != 0 || m_valid) && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_drained"}, 64'(exp_d.size()), 64'd0);
    endtask

    initial begin
        int n;
        int rem;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_wc", 64'(word_count), 64'd0);
        chk("rst_pc", 64'(pkt_count), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);

        // T1 latency
        do_reset();
        push_words(32'hA5, 1);
        tick();
        enable = 1'b1;
        #1;
        chk("t1_ren_N", {63'd0, fifo_r_en}, 64'd1);
        tick();
        chk("t1_valid_N1", {63'd0, m_valid}, 64'd0);
        tick();
        chk("t1_valid_N2", {63'd0, m_valid}, 64'd1);
        chk("t1_data_N2", 64'(m_data), 64'hA5);
        tick();
        chk("t1_valid_N3", {63'd0, m_valid}, 64'd0);
        enable = 1'b0;
        tick();

        // T2 streaming
        do_reset();
        push_words(32'd0, 64);
        tick();
        enable = 1'b1;
        wait_valid("t2", 20);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (m_valid) n++;
            tick();
        end
        chk("t2_consecutive", 64'(n), 64'd64);
        chk("t2_valid_after", {63'd0, m_valid}, 64'd0);
        chk("t2_wc", 64'(word_count), 64'd64);
        chk("t2_pc", 64'(pkt_count), 64'd8);
        chk("t2_len1_pc", 64'(pc3), 64'd64);
        enable = 1'b0;
        tick();

        // T3 backpressure
        do_reset();
        push_words(32'h100, 20);
        tick();
        enable = 1'b1;
        wait_valid("t3", 20);
        repeat (5) tick();
        m_ready = 1'b0;
        repeat (10) tick();
        chk("t3_ren_stalled", {63'd0, fifo_r_en}, 64'd0);
        chk("t3_outstanding", 64'(issued - xfer), 64'd3);
        chk("t3_valid_held", {63'd0, m_valid}, 64'd1);
        rem = 20 - xfer;
        m_ready = 1'b1;
        n = 0;
        for (int i = 0; i < rem; i++) begin
            if (m_valid) n++;
            tick();
        end
        chk("t3_full_rate", 64'(n), 64'(rem));
        wait_drain("t3", 20);
        chk("t3_wc", 64'(word_count), 64'd20);
        enable = 1'b0;
        tick();

        // T4 empty boundary
        do_reset();
        push_words(32'h200, 5);
        tick();
        enable = 1'b1;
        wait_drain("t4a", 30);
        for (int i = 0; i < 4; i++) begin
            chk("t4_empty_valid", {63'd0, m_valid}, 64'd0);
            chk("t4_busy_held", {63'd0, busy}, 64'd1);
            tick();
        end
        push_words(32'h300, 3);
        wait_drain("t4b", 30);
        chk("t4_wc", 64'(word_count), 64'd8);
        chk("t4_pc", 64'(pkt_count), 64'd1);
        enable = 1'b0;
        tick();

        // T5 drain
        do_reset();
        push_words(32'h400, 10);
        tick();
        enable  = 1'b1;
        m_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("t5_outstanding", 64'(issued - xfer), 64'd3);
        chk("t5_valid_c4", {63'd0, m_valid}, 64'd1);
        enable  = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t5_ren_drain", {63'd0, fifo_r_en}, 64'd0);
            chk("t5_busy_drain", {63'd0, busy}, 64'd1);
            chk("t5_valid_drain", {63'd0, m_valid}, 64'd1);
        end
        tick();
        chk("t5_valid_end", {63'd0, m_valid}, 64'd0);
        chk("t5_busy_end", {63'd0, busy}, 64'd0);
        chk("t5_ren_end", {63'd0, fifo_r_en}, 64'd0);
        chk("t5_wc", 64'(word_count), 64'd3);

        // T6 counter wrap and reset mid-packet
        do_reset();
        push_words(32'h500, 17);
        tick();
        enable = 1'b1;
        wait_drain("t6a", 60);
        chk("t6_wc16", 64'(word_count), 64'd17);
        chk("t6_pc16", 64'(pkt_count), 64'd2);
        chk("t6_wc4_wrap", 64'(wc2), 64'd1);
        chk("t6_pc4", 64'(pc2), 64'd2);
        push_words(32'h600, 3);
        wait_drain("t6b", 30);
        m_ready = 1'b0;
        push_words(32'h700, 2);
        repeat (4) tick();
        chk("t6_pre_rst_valid", {63'd0, m_valid}, 64'd1);
        chk("t6_pre_rst_data", 64'(m_data), 64'h700);
        do_reset();
        chk("t6_rst_valid", {63'd0, m_valid}, 64'd0);
        chk("t6_rst_last", {63'd0, m_last}, 64'd0);
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_data", 64'(m_data), 64'd0);
        chk("t6_rst_wc", 64'(word_count), 64'd0);
        chk("t6_rst_pc", 64'(pkt_count), 64'd0);
        m_ready = 1'b1;
        push_words(32'h800, 8);
        wait_drain("t6c", 30);
        chk("t6_fresh_pc", 64'(pkt_count), 64'd1);
        chk("t6_fresh_wc", 64'(word_count), 64'd8);
        enable = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
